id_ex_stage: RTL

- ID/EX pipeline register of the RV32I 5-stage pipeline, with integrated load-use hazard detection.
- Captures the control-unit outputs (ALUop, ALUsrc, MtoR, regwrite, memread, memwrite, branch), register-file read data, immediate, PC and register indices from decode, and presents them to execute one cycle later.
- Inserts bubbles on load-use hazards and branch flushes, and holds on downstream back-pressure.

---
 rtl/id_ex_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection.
// Optional ID_EX_PERF_EN adds stall/flush bubble counters.
module id_ex_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        id_aluop,
   input  logic              id_alusrc,
   input  logic              id_mtor,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              id_memwrite,
   input  logic              id_branch,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   id_rs1_data,
   input  logic [XLEN-1:0]   id_rs2_data,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [3:0]        id_funct,
   input  logic              flush,
   input  logic              hold,
   output logic [1:0]        ex_aluop,
   output logic              ex_alusrc,
   output logic              ex_mtor,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic              ex_memwrite,
   output logic              ex_branch,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_rs1_data,
   output logic [XLEN-1:0]   ex_rs2_data,
   output logic [XLEN-1:0]   ex_imm,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [REG_AW-1:0] ex_rd,
   output logic [3:0]        ex_funct,
`ifdef ID_EX_PERF_EN
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_flush_cnt,
`endif
   output logic              stall
);

   typedef struct packed {
      logic [1:0]        aluop;
      logic              alusrc;
      logic              mtor;
      logic              regwrite;
      logic              memread;
      logic              memwrite;
      logic              branch;
      logic              valid;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   rs1_data;
      logic [XLEN-1:0]   rs2_data;
      logic [XLEN-1:0]   imm;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic [3:0]        funct;
   } ex_fields_t;

   ex_fields_t ex_q, ex_d;
   logic       stall_c;

   // A load in EX whose rd feeds the decode instruction must wait one cycle.
   assign stall_c = ex_q.valid & ex_q.memread & (ex_q.rd != '0) & id_valid &
                    ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2)) & ~flush & ~hold;
   assign stall   = stall_c;

   always_comb begin
      ex_d = ex_q;
      if (flush || stall_c) begin
         ex_d = '0;
      end else if (!hold) begin
         ex_d.aluop    = id_aluop;
         ex_d.alusrc   = id_alusrc;
         ex_d.mtor     = id_mtor;
         ex_d.regwrite = id_regwrite & id_valid;
         ex_d.memread  = id_memread  & id_valid;
         ex_d.memwrite = id_memwrite & id_valid;
         ex_d.branch   = id_branch   & id_valid;
         ex_d.valid    = id_valid;
         ex_d.pc       = id_pc;
         ex_d.rs1_data = id_rs1_data;
         ex_d.rs2_data = id_rs2_data;
         ex_d.imm      = id_imm;
         ex_d.rs1      = id_rs1;
         ex_d.rs2      = id_rs2;
         ex_d.rd       = id_rd;
         ex_d.funct    = id_funct;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ex_q <= '0;
      else     ex_q <= ex_d;
   end

   assign ex_aluop    = ex_q.aluop;
   assign ex_alusrc   = ex_q.alusrc;
   assign ex_mtor     = ex_q.mtor;
   assign ex_regwrite = ex_q.regwrite;
   assign ex_memread  = ex_q.memread;
   assign ex_memwrite = ex_q.memwrite;
   assign ex_branch   = ex_q.branch;
   assign ex_valid    = ex_q.valid;
   assign ex_pc       = ex_q.pc;
   assign ex_rs1_data = ex_q.rs1_data;
   assign ex_rs2_data = ex_q.rs2_data;
   assign ex_imm      = ex_q.imm;
   assign ex_rs1      = ex_q.rs1;
   assign ex_rs2      = ex_q.rs2;
   assign ex_rd       = ex_q.rd;
   assign ex_funct    = ex_q.funct;

`ifdef ID_EX_PERF_EN
   logic [31:0] perf_stall_cnt_q, perf_flush_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cnt_q <= '0;
         perf_flush_cnt_q <= '0;
      end else begin
         if (stall_c) perf_stall_cnt_q <= perf_stall_cnt_q + 32'd1;
         if (flush)   perf_flush_cnt_q <= perf_flush_cnt_q + 32'd1;
      end
   end

   assign perf_stall_cnt = perf_stall_cnt_q;
   assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule
